// File: rtl/demux_decoded_buffered.sv
// One-hot select demultiplexer: steers each accepted payload into a single-entry
// buffer for the selected way; every way has its own valid/ready output channel.
module demux_decoded_buffered #(
    parameter int SINGLE_WAY_WIDTH_IN_BITS = 4,
    parameter int NUM_WAY                  = 8
) (
    input  logic                                         clk_in,
    input  logic                                         reset_in,
    input  logic [SINGLE_WAY_WIDTH_IN_BITS-1:0]          data_in,
    input  logic [NUM_WAY-1:0]                           sel_in,
    input  logic                                         valid_in,
    output logic                                         ready_out,
    output logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0]  way_flatted_out,
    output logic [NUM_WAY-1:0]                           valid_out,
    input  logic [NUM_WAY-1:0]                           ready_in,
    output logic                                         sel_error_out
);

    localparam int W = SINGLE_WAY_WIDTH_IN_BITS;

    logic [W*NUM_WAY-1:0] data_q, data_d;
    logic [NUM_WAY-1:0]   valid_q, valid_d;
    logic                 err_q, err_d;

    logic [NUM_WAY-1:0]   sel_minus_one;
    logic                 sel_legal;
    logic                 accept;
    logic [NUM_WAY-1:0]   fill;
    logic [NUM_WAY-1:0]   drain;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign sel_minus_one = sel_in - NUM_WAY'(1);
    assign sel_legal     = (sel_in != '0) && ((sel_in & sel_minus_one) == '0);

    // Illegal selects are always swallowed so a bad producer can never deadlock.
    assign ready_out = sel_legal ? |(sel_in & (~valid_q | ready_in)) : 1'b1;
    assign accept    = valid_in & ready_out;
    assign fill      = (accept && sel_legal) ? sel_in : '0;
    assign drain     = valid_q & ready_in;

    always_comb begin
        data_d  = data_q;
        valid_d = (valid_q & ~drain) | fill;
        err_d   = err_q | (accept & ~sel_legal);
        for (int i = 0; i < NUM_WAY; i++) begin
            if (fill[i]) begin
                data_d[i*W +: W] = data_in;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            data_q  <= '0;
            valid_q <= '0;
            err_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign way_flatted_out = data_q;
    assign valid_out       = valid_q;
    assign sel_error_out   = err_q;

endmodule
